param_multicycle_cpu: RTL

- Parametrised successor of the team's 16-bit multicycle processor: generic data width and register-file depth, eight-opcode ALU, run/done handshake and latched status flags.
- Executes one instruction per `run` request over 2 or 4 cycles.
- All transfers use one internal shared bus, observable on `bus_out`.
- Sits between an instruction source (testbench, ROM sequencer) and downstream debug/IO logic.

---
 rtl/param_multicycle_cpu_if.sv | 14 +
 rtl/param_multicycle_cpu.sv | 137 +++++++++++++
 2 files changed

// File: rtl/param_multicycle_cpu_if.sv
// Instruction/handshake/status bundle between an instruction source and param_multicycle_cpu.
interface param_multicycle_cpu_if #(parameter int DATA_W = 16);
    logic              run;
    logic [DATA_W-1:0] iin;
    logic              done;
    logic              busy;
    logic [DATA_W-1:0] bus_out;
    logic              flag_z;
    logic              flag_n;
    logic              flag_c;

    modport master (output run, iin, input done, busy, bus_out, flag_z, flag_n, flag_c);
    modport slave  (input run, iin, output done, busy, bus_out, flag_z, flag_n, flag_c);
endinterface

// File: rtl/param_multicycle_cpu.sv
// Parametrised multicycle CPU: one instruction per run over 2 (mv/mvi) or 4 (ALU) cycles,
// all transfers over one shared bus.
module param_multicycle_cpu #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8
) (
    input logic                  clk,
    input logic                  resetn,
    param_multicycle_cpu_if.slave cpu
);
    localparam int REG_AW = $clog2(NREGS);
    localparam int IMM_W  = DATA_W - 3 - 2 * REG_AW;

    typedef enum logic [1:0] {T0, T1, T2, T3} state_t;
    typedef enum logic [2:0] {
        OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NEG
    } op_t;
    typedef struct packed {
        op_t              op;
        logic [REG_AW-1:0] rx;
        logic [REG_AW-1:0] ry;
        logic [IMM_W-1:0]  imm;
    } instr_t;

    state_t                        state_q, state_d;
    instr_t                        ir_q, ir_d;
    logic [DATA_W-1:0]             a_q, a_d, g_q, g_d;
    logic [NREGS-1:0][DATA_W-1:0]  r_q, r_d;
    logic                          z_q, z_d, n_q, n_d, c_q, c_d;

    logic [DATA_W-1:0] bus, imm_ext, alu_b, alu_res;
    logic [DATA_W:0]   sum;
    logic              alu_c, done;

    assign imm_ext = {{(DATA_W-IMM_W){ir_q.imm[IMM_W-1]}}, ir_q.imm};

    always_comb begin
        bus = '0;
        case (state_q)
            T1: begin
                case (ir_q.op)
                    OP_MV:   bus = r_q[ir_q.ry];
                    OP_MVI:  bus = imm_ext;
                    OP_NEG:  bus = '0;
                    default: bus = r_q[ir_q.rx];
                endcase
            end
            T2:      bus = r_q[ir_q.ry];
            T3:      bus = g_q;
            default: bus = '0;
        endcase
    end

    // sub/neg share the adder as A + ~bus + 1; neg works because A was loaded with 0
    always_comb begin
        alu_b = (ir_q.op == OP_ADD) ? bus : ~bus;
        sum   = {1'b0, a_q} + {1'b0, alu_b} + {{DATA_W{1'b0}}, (ir_q.op != OP_ADD)};
        case (ir_q.op)
            OP_AND:  alu_res = a_q & bus;
            OP_OR:   alu_res = a_q | bus;
            OP_XOR:  alu_res = a_q ^ bus;
            default: alu_res = sum[DATA_W-1:0];
        endcase
        alu_c = ((ir_q.op == OP_ADD) || (ir_q.op == OP_SUB)) ? sum[DATA_W] : 1'b0;
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        a_d     = a_q;
        g_d     = g_q;
        r_d     = r_q;
        z_d     = z_q;
        n_d     = n_q;
        c_d     = c_q;
        done    = 1'b0;
        case (state_q)
            T0: begin
                if (cpu.run) begin
                    ir_d    = instr_t'(cpu.iin);
                    state_d = T1;
                end
            end
            T1: begin
                if ((ir_q.op == OP_MV) || (ir_q.op == OP_MVI)) begin
                    r_d[ir_q.rx] = bus;
                    done         = 1'b1;
                    state_d      = T0;
                end else begin
                    a_d     = bus;
                    state_d = T2;
                end
            end
            T2: begin
                g_d     = alu_res;
                z_d     = (alu_res == '0);
                n_d     = alu_res[DATA_W-1];
                c_d     = alu_c;
                state_d = T3;
            end
            default: begin
                r_d[ir_q.rx] = bus;
                done         = 1'b1;
                state_d      = T0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= T0;
            ir_q    <= '0;
            a_q     <= '0;
            g_q     <= '0;
            r_q     <= '0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            g_q     <= g_d;
            r_q     <= r_d;
            z_q     <= z_d;
            n_q     <= n_d;
            c_q     <= c_d;
        end
    end

    assign cpu.done    = done;
    assign cpu.busy    = (state_q != T0);
    assign cpu.bus_out = bus;
    assign cpu.flag_z  = z_q;
    assign cpu.flag_n  = n_q;
    assign cpu.flag_c  = c_q;
endmodule
